// File: rtl/gpt_pkg.sv
// Shared encodings for the general-purpose timer slave mode controller:
// slave-mode / trigger-select codes, FSM states and the output bundle.
package gpt_pkg;

  typedef enum logic [2:0] {
    SMS_DISABLED = 3'b000,
    SMS_RESET    = 3'b100,
    SMS_GATED    = 3'b101,
    SMS_TRIGGER  = 3'b110,
    SMS_EXT_CLK  = 3'b111
  } sms_e;

  typedef enum logic [2:0] {
    TS_ITR0   = 3'b000,
    TS_ITR1   = 3'b001,
    TS_ITR2   = 3'b010,
    TS_ITR3   = 3'b011,
    TS_TI1FP1 = 3'b100,
    TS_TI2FP2 = 3'b101,
    TS_ETRF   = 3'b110,
    TS_NONE   = 3'b111
  } ts_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ACTIVE,
    ST_TRIGGERED
  } smc_state_e;

  typedef struct packed {
    logic rst;
    logic gate;
    logic trig;
    logic ext_clk_en;
    logic tif;
  } smc_out_t;

  localparam smc_out_t SMC_OUT_RST = '{rst: 1'b0, gate: 1'b1, trig: 1'b0,
                                       ext_clk_en: 1'b0, tif: 1'b0};

  // Unlisted slave-mode codes fold onto "disabled".
  function automatic sms_e decode_sms(input logic [2:0] code);
    case (code)
      3'b100:  return SMS_RESET;
      3'b101:  return SMS_GATED;
      3'b110:  return SMS_TRIGGER;
      3'b111:  return SMS_EXT_CLK;
      default: return SMS_DISABLED;
    endcase
  endfunction

endpackage

// File: rtl/slave_mode_controller_if.sv
// Mode/trigger inputs and time-base control outputs of the slave mode
// controller; slave modport is the controller, master the surrounding timer.
interface slave_mode_controller_if;
  logic [2:0] sms_i;
  logic [2:0] ts_i;
  logic [3:0] itr_i;
  logic       ti1fp1_i;
  logic       ti2fp2_i;
  logic       etr_i;
  logic       etp_i;
  logic       msm_i;
  logic       cen_i;
  logic       sm_reset_o;
  logic       sm_gate_o;
  logic       sm_trig_o;
  logic       ext_clk_en_o;
  logic       tif_o;

  modport slave (
    input  sms_i, ts_i, itr_i, ti1fp1_i, ti2fp2_i, etr_i, etp_i, msm_i, cen_i,
    output sm_reset_o, sm_gate_o, sm_trig_o, ext_clk_en_o, tif_o
  );

  modport master (
    output sms_i, ts_i, itr_i, ti1fp1_i, ti2fp2_i, etr_i, etp_i, msm_i, cen_i,
    input  sm_reset_o, sm_gate_o, sm_trig_o, ext_clk_en_o, tif_o
  );
endinterface

// File: rtl/slave_mode_controller_trigger_filter.sv
// TRGI glitch filter: output follows the input only after FILTER_LEN
// consecutive equal samples. Compiled only with SMC_TRIG_FILTER_EN.
`ifdef SMC_TRIG_FILTER_EN
module trigger_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic aresetn_i,
  input  logic clr_i,
  input  logic raw_i,
  output logic filt_o
);

  logic [3:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      cnt    <= '0;
      filt_o <= 1'b0;
    end else if (clr_i || (raw_i == filt_o)) begin
      cnt <= '0;
    end else if (cnt == 4'(FILTER_LEN - 1)) begin
      filt_o <= raw_i;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule
`endif

// File: rtl/slave_mode_controller.sv
// Timer slave mode controller: selects TRGI, detects its edges and drives the
// time base reset/gate/trigger/external-clock controls. Optional TRGI filter
// is enabled by defining SMC_TRIG_FILTER_EN.
module slave_mode_controller
  import gpt_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input logic                     clk_i,
  input logic                     aresetn_i,
  slave_mode_controller_if.slave  bus
);

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("FILTER_LEN must be in 2..15");
  end

  logic       etr_s1, etr_s2;
  logic [2:0] sms_q, ts_q;
  logic       trgi_raw, trgi, trgi_q;
  logic       cfg_change, edge_r, edge_f;
  sms_e       mode;
  smc_state_e state, state_nxt;
  smc_out_t   p1, p1_nxt, p2, out_sel;

  assign mode       = decode_sms(bus.sms_i);
  assign cfg_change = (bus.sms_i != sms_q) || (bus.ts_i != ts_q);
  assign edge_r     = trgi & ~trgi_q;
  assign edge_f     = ~trgi & trgi_q;

  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      etr_s1 <= 1'b0;
      etr_s2 <= 1'b0;
      trgi_q <= 1'b0;
      sms_q  <= '0;
      ts_q   <= '0;
    end else begin
      etr_s1 <= bus.etr_i;
      etr_s2 <= etr_s1;
      trgi_q <= trgi;
      sms_q  <= bus.sms_i;
      ts_q   <= bus.ts_i;
    end
  end

  always_comb begin
    trgi_raw = 1'b0;
    case (ts_e'(bus.ts_i))
      TS_ITR0, TS_ITR1, TS_ITR2, TS_ITR3: trgi_raw = bus.itr_i[bus.ts_i[1:0]];
      TS_TI1FP1: trgi_raw = bus.ti1fp1_i;
      TS_TI2FP2: trgi_raw = bus.ti2fp2_i;
      TS_ETRF:   trgi_raw = etr_s2 ^ bus.etp_i;
      default:   trgi_raw = 1'b0;
    endcase
  end

`ifdef SMC_TRIG_FILTER_EN
  logic ts_change;
  assign ts_change = (bus.ts_i != ts_q);

  trigger_filter #(.FILTER_LEN(FILTER_LEN)) u_trigger_filter (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .clr_i     (ts_change),
    .raw_i     (trgi_raw),
    .filt_o    (trgi)
  );
`else
  assign trgi = trgi_raw;
`endif

  // Config changes win over edges: the edge seen on the change cycle is
  // against the old source, so it is dropped and PRIME re-baselines trgi_q.
  always_comb begin
    state_nxt = state;
    p1_nxt    = SMC_OUT_RST;
    if (mode == SMS_GATED) p1_nxt.gate = trgi;
    if (mode == SMS_DISABLED) begin
      state_nxt = ST_IDLE;
    end else if (state == ST_IDLE || cfg_change) begin
      state_nxt = ST_PRIME;
    end else begin
      case (state)
        ST_PRIME: state_nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          case (mode)
            SMS_RESET: begin
              p1_nxt.rst = edge_r;
              p1_nxt.tif = edge_r;
            end
            SMS_GATED:   p1_nxt.tif = edge_r | edge_f;
            SMS_TRIGGER: begin
              if (edge_r) begin
                p1_nxt.trig = 1'b1;
                p1_nxt.tif  = 1'b1;
                state_nxt   = ST_TRIGGERED;
              end
            end
            SMS_EXT_CLK: p1_nxt.ext_clk_en = edge_r;
            default: ;
          endcase
        end
        ST_TRIGGERED: if (!bus.cen_i) state_nxt = ST_ACTIVE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      state <= ST_IDLE;
      p1    <= SMC_OUT_RST;
      p2    <= SMC_OUT_RST;
    end else begin
      state <= state_nxt;
      p1    <= p1_nxt;
      p2    <= p1;
      if (cfg_change) begin
        p2.rst        <= 1'b0;
        p2.trig       <= 1'b0;
        p2.ext_clk_en <= 1'b0;
        p2.tif        <= 1'b0;
      end
    end
  end

  assign out_sel          = bus.msm_i ? p2 : p1;
  assign bus.sm_reset_o   = out_sel.rst;
  assign bus.sm_gate_o    = out_sel.gate;
  assign bus.sm_trig_o    = out_sel.trig;
  assign bus.ext_clk_en_o = out_sel.ext_clk_en;
  assign bus.tif_o        = out_sel.tif;

endmodule

// File: doc/slave_mode_controller.md
SLAVE_MODE_CONTROLLER -- requirements
Module: slave_mode_controller

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples required by the trigger filter (2..15).
REQ-002 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port aresetn_i  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port sms_i  input  3  slave mode select: 000 disabled, 100 reset, 101 gated, 110 trigger, 111 external clock; other codes behave as 000.
REQ-005 SHALL have port ts_i  input  3  trigger select: 000-011 itr_i[ts], 100 ti1fp1_i, 101 ti2fp2_i, 110 etr_i, 111 none (TRGI=0).
REQ-006 SHALL have port itr_i  input  4  internal triggers, synchronous to clk_i.
REQ-007 SHALL have ports ti1fp1_i, ti2fp2_i  input  1 each  filtered channel inputs, synchronous.
REQ-008 SHALL have port etr_i  input  1  external trigger, asynchronous.
REQ-009 SHALL have port etp_i  input  1  etr polarity; 1 inverts etr after synchronization.
REQ-010 SHALL have port msm_i  input  1  master/slave sync; 1 delays every output by one cycle.
REQ-011 SHALL have port cen_i  input  1  counter enable from time base, used to re-arm trigger mode.
REQ-012 SHALL have ports sm_reset_o, sm_gate_o, sm_trig_o  output  1 each  drive sm_reset_i/sm_gate_i/sm_trig_i of time_base_unit.
REQ-013 SHALL have port ext_clk_en_o  output  1  one-cycle count-enable per TRGI rising edge in external clock mode.
REQ-014 SHALL have port tif_o  output  1  one-cycle trigger-event flag.

Function
REQ-015 etr_i SHALL pass a 2-flop synchronizer before polarity and selection; other sources SHALL NOT be synchronized.
REQ-016 TRGI rising edge SHALL be detected as TRGI=1 with previous registered TRGI=0; output pulses SHALL be registered, one cycle wide, asserted the cycle after the edge is sampled (etr: +2 cycles; msm_i=1: +1 cycle).
REQ-017 FSM states SHALL be IDLE, PRIME, ACTIVE, TRIGGERED.
REQ-018 IDLE: entered when sms_i is disabled; all pulse outputs 0, sm_gate_o=1; go to PRIME when sms_i becomes a valid mode.
REQ-019 PRIME: one cycle; loads previous-TRGI register with current TRGI so a level already high produces no edge; then ACTIVE.
REQ-020 Any change of sms_i or ts_i from PRIME/ACTIVE/TRIGGERED SHALL go to PRIME (IDLE if new sms_i disabled); pending pulses SHALL be dropped.
REQ-021 Reset mode: each edge in ACTIVE SHALL pulse sm_reset_o and tif_o; sm_gate_o=1.
REQ-022 Gated mode: sm_gate_o SHALL equal registered TRGI (delayed per REQ-016); tif_o SHALL pulse on both edges of TRGI; no other pulses.
REQ-023 Trigger mode: first edge in ACTIVE SHALL pulse sm_trig_o and tif_o and go to TRIGGERED; edges in TRIGGERED SHALL be ignored; TRIGGERED returns to ACTIVE when cen_i is sampled 0.
REQ-024 External clock mode: each edge SHALL pulse ext_clk_en_o; tif_o SHALL NOT pulse; sm_gate_o=1.
REQ-025 Outputs SHALL be mutually exclusive except tif_o; edges on consecutive cycles SHALL yield consecutive pulses.

Reset
REQ-026 With aresetn_i=0 at a clock edge: FSM=IDLE, synchronizer/filter/edge/delay registers=0, sm_gate_o=1, all other outputs=0.
REQ-027 Reset asserted mid-pulse SHALL clear the pulse in the same clock edge; first edge after reset release SHALL be honoured only after PRIME.

Configuration
REQ-028 Macro SMC_TRIG_FILTER_EN defined: TRGI SHALL change only after FILTER_LEN consecutive equal samples of the selected source, adding FILTER_LEN cycles latency; filter counter resets on ts_i change.
REQ-029 Macro undefined: no filter logic; TRGI is the selected source directly; FILTER_LEN unused.

Structure
REQ-030 Package gpt_pkg SHALL hold the sms and ts encodings as enums and the FSM state typedef.
REQ-031 Sub-module trigger_filter SHALL implement REQ-028 (instantiated only under the macro).

Verification
REQ-032 sms=100, ts=000, itr[0] 0->1 at cycle 10 -> sm_reset_o and tif_o high cycle 11 only.
REQ-033 sms=110, two itr[1] edges at cycles 10 and 20, cen_i=1 throughout -> one sm_trig_o pulse at cycle 11; drop cen_i at 25, edge at 30 -> pulse at 31.
REQ-034 sms=101, ts=110, etp=1, etr_i low cycles 10-19 -> sm_gate_o high cycles 13-22, tif_o at 13 and 23.
REQ-035 sms=111, itr[2] toggling every cycle for 8 cycles -> 4 ext_clk_en_o pulses, no tif_o.
REQ-036 itr[0] held high, sms switched 000->100 -> no sm_reset_o; aresetn_i=0 during pulse cycle -> pulse cleared, outputs at reset values.
